// File: rtl/lbist_tpg_pkg.sv
// Shared definitions for the LBIST pattern generator: run-control states,
// the list of LFSR widths we have polynomials for, and the tap table.
package lbist_pkg;

  localparam int MAX_N      = 32;
  localparam int NUM_WIDTHS = 5;

  localparam int SUPPORTED_WIDTHS [NUM_WIDTHS] = '{7, 16, 19, 20, 32};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } tpg_state_e;

  // True when a maximal-length polynomial is tabulated for width n.
  function automatic bit width_supported(input int n);
    for (int i = 0; i < NUM_WIDTHS; i++) begin
      if (SUPPORTED_WIDTHS[i] == n) begin
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Tap mask for an n-bit Fibonacci LFSR shifting towards bit 0.
  // A 1-based tap t selects state bit (n - t), so the highest tap always
  // lands on bit 0.
  //   7 : {7,3}        -> bits 0,4
  //   16: {16,15,13,4} -> bits 0,1,3,12
  //   19: {19,5,2,1}   -> bits 0,14,17,18
  //   20: {20,3}       -> bits 0,17
  //   32: {32,22,2,1}  -> bits 0,10,30,31
  function automatic logic [MAX_N-1:0] tap_mask(input int n);
    logic [MAX_N-1:0] mask;
    mask = '0;
    case (n)
      7:       mask = 32'h0000_0011;
      16:      mask = 32'h0000_100B;
      19:      mask = 32'h0006_4001;
      20:      mask = 32'h0002_0001;
      32:      mask = 32'hC000_0401;
      default: mask = '0;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lbist_tpg_if.sv
// Pattern delivery channel between the generator and the scan-chain loader.
// The generator drives the pattern and its valid flag; the loader answers
// with ready.
interface lbist_tpg_if #(
  parameter int N = 20
);

  logic [N-1:0] pat_o;
  logic         pat_valid_o;
  logic         pat_ready_i;

  modport master (
    output pat_o,
    output pat_valid_o,
    input  pat_ready_i
  );

  modport slave (
    input  pat_o,
    input  pat_valid_o,
    output pat_ready_i
  );

endinterface

// File: rtl/lbist_tpg_lfsr_step.sv
// One step of an N-bit XNOR Fibonacci LFSR. Purely combinational so the same
// next-state function can be shared with the signature register.
// The all-ones state is the lock-up state of the XNOR form.
module lbist_lfsr_step
  import lbist_pkg::*;
#(
  parameter int N = 20
) (
  input  logic [N-1:0] state,
  output logic [N-1:0] next_state
);

  localparam logic [MAX_N-1:0] TAPS_FULL = tap_mask(N);
  localparam logic [N-1:0]     TAPS      = TAPS_FULL[N-1:0];

  logic fb;

  // Feedback is the XNOR of the tapped bits, shifted in at the top.
  always_comb begin
    fb         = ~^(state & TAPS);
    next_state = {fb, state[N-1:1]};
  end

endmodule

// File: rtl/lbist_tpg.sv
// LBIST test-pattern generator: bounded, stallable LFSR pattern source with
// start/abort run control and a per-run pattern counter.
// Optional runtime reseeding is enabled by defining LBIST_TPG_RESEED_EN;
// without it the seed inputs are ignored and the LFSR only ever starts from
// SEED after reset.
module lbist_tpg
  import lbist_pkg::*;
#(
  parameter int           N    = 20,
  parameter logic [N-1:0] SEED = N'(1),
  parameter int           NPAT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic                      seed_we_i,
  input  logic [N-1:0]              seed_i,
  lbist_tpg_if.master               pat_if,
  output logic [$clog2(NPAT+1)-1:0] pat_cnt_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      seed_err_o
);

  localparam int           CW          = $clog2(NPAT + 1);
  localparam logic [CW-1:0] LAST_CNT_M1 = CW'(NPAT - 1);
  localparam logic [N-1:0]  ALL_ONES    = '1;

  if (!width_supported(N)) begin : g_bad_width
    $fatal(1, "lbist_tpg: unsupported LFSR width N=%0d", N);
  end

  if (SEED == ALL_ONES) begin : g_bad_seed
    $fatal(1, "lbist_tpg: SEED must not be the all-ones lock-up state");
  end

  if (NPAT < 1) begin : g_bad_npat
    $fatal(1, "lbist_tpg: NPAT must be at least 1");
  end

  tpg_state_e    state_q;
  tpg_state_e    state_d;
  logic [N-1:0]  lfsr_q;
  logic [N-1:0]  lfsr_d;
  logic [N-1:0]  lfsr_next;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          seed_err_q;
  logic          seed_err_d;

  logic          seed_load;
  logic          seed_bad;
  logic [N-1:0]  seed_val;

  lbist_lfsr_step #(
    .N (N)
  ) u_step (
    .state      (lfsr_q),
    .next_state (lfsr_next)
  );

`ifdef LBIST_TPG_RESEED_EN
  // A seed write is only honoured outside a run; an all-ones seed would
  // lock the LFSR, so it is replaced by SEED and flagged.
  assign seed_load = seed_we_i && (state_q != ST_RUN);
  assign seed_bad  = seed_load && (seed_i == ALL_ONES);
  assign seed_val  = (seed_i == ALL_ONES) ? SEED : seed_i;
`else
  logic unused_seed;
  assign unused_seed = ^{seed_we_i, seed_i};
  assign seed_load   = 1'b0;
  assign seed_bad    = 1'b0;
  assign seed_val    = SEED;
`endif

  // Run control: decides the next FSM state, LFSR contents and count.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    seed_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (seed_load) begin
          lfsr_d     = seed_val;
          seed_err_d = seed_bad;
        end
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (pat_if.pat_ready_i) begin
          lfsr_d = lfsr_next;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT_M1) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (seed_load) begin
          lfsr_d     = seed_val;
          seed_err_d = seed_bad;
          state_d    = ST_IDLE;
        end
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, LFSR, counter and error-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      cnt_q      <= '0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      seed_err_q <= seed_err_d;
    end
  end

  assign pat_if.pat_o       = lfsr_q;
  assign pat_if.pat_valid_o = (state_q == ST_RUN);
  assign pat_cnt_o          = cnt_q;
  assign busy_o             = (state_q == ST_RUN);
  assign done_o             = (state_q == ST_DONE);
  assign seed_err_o         = seed_err_q;

endmodule

// File: tb/tb_lbist_tpg.sv
// Testbench for lbist_tpg. Two instances: a 7-bit generator (SEED=1,
// NPAT=10) for sequence, period, abort, stall and reset behaviour, and a
// 16-bit generator (SEED=1, NPAT=4) for throttled handshakes and seeding.
// Patterns are queued when a handshake is driven and compared by monitors.
module tb_lbist_tpg;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: N=7
  logic       a_start;
  logic       a_abort;
  logic       a_we;
  logic [6:0] a_seed;
  logic [3:0] a_cnt;
  logic       a_busy;
  logic       a_done;
  logic       a_err;

  lbist_tpg_if #(.N(7)) a_if();

  lbist_tpg #(
    .N    (7),
    .SEED (7'h01),
    .NPAT (10)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .start_i    (a_start),
    .abort_i    (a_abort),
    .seed_we_i  (a_we),
    .seed_i     (a_seed),
    .pat_if     (a_if),
    .pat_cnt_o  (a_cnt),
    .busy_o     (a_busy),
    .done_o     (a_done),
    .seed_err_o (a_err)
  );

  // Instance B: N=16
  logic        b_start;
  logic        b_abort;
  logic        b_we;
  logic [15:0] b_seed;
  logic [2:0]  b_cnt;
  logic        b_busy;
  logic        b_done;
  logic        b_err;

  lbist_tpg_if #(.N(16)) b_if();

  lbist_tpg #(
    .N    (16),
    .SEED (16'h0001),
    .NPAT (4)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .start_i    (b_start),
    .abort_i    (b_abort),
    .seed_we_i  (b_we),
    .seed_i     (b_seed),
    .pat_if     (b_if),
    .pat_cnt_o  (b_cnt),
    .busy_o     (b_busy),
    .done_o     (b_done),
    .seed_err_o (b_err)
  );

  // Scoreboards hold {pattern, count-before-handshake}
  logic [10:0] sb_a[$];
  logic [18:0] sb_b[$];
  logic [10:0] exp_a;
  logic [18:0] exp_b;

  logic [6:0]  m7;
  logic [3:0]  mcnt7;
  logic [15:0] m16;
  logic [2:0]  mcnt16;

  int seen7 [128];

  // Taps 7,3 -> bits 0,4
  function automatic logic [6:0] next7(input logic [6:0] s);
    return {~(s[0] ^ s[4]), s[6:1]};
  endfunction

  // Taps 16,15,13,4 -> bits 0,1,3,12
  function automatic logic [15:0] next16(input logic [15:0] s);
    return {~(s[0] ^ s[1] ^ s[3] ^ s[12]), s[15:1]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic abort, input logic ready);
    a_start          = start;
    a_abort          = abort;
    a_if.pat_ready_i = ready;
    tick();
  endtask

  task automatic applyStimulusB(input logic start, input logic abort, input logic ready);
    b_start          = start;
    b_abort          = abort;
    b_if.pat_ready_i = ready;
    tick();
  endtask

  task automatic runHandshakesA(input int n);
    for (int i = 0; i < n; i++) begin
      sb_a.push_back({m7, mcnt7});
      m7    = next7(m7);
      mcnt7 = mcnt7 + 4'd1;
      applyStimulus(1'b0, 1'b0, 1'b1);
    end
    a_if.pat_ready_i = 1'b0;
  endtask

  task automatic runHandshakesB(input int n);
    for (int i = 0; i < n; i++) begin
      sb_b.push_back({m16, mcnt16});
      m16    = next16(m16);
      mcnt16 = mcnt16 + 3'd1;
      applyStimulusB(1'b0, 1'b0, 1'b1);
    end
    b_if.pat_ready_i = 1'b0;
  endtask

  // Monitor for instance A: every accepted pattern is matched against the queue.
  always @(negedge clk) begin
    if (!rst && a_if.pat_valid_o && a_if.pat_ready_i && !a_abort) begin
      if (sb_a.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL a_unexpected_handshake: got pat 0x%0h expected none", a_if.pat_o);
      end else begin
        exp_a = sb_a.pop_front();
        checkOutput("a_pat", {25'd0, a_if.pat_o}, {25'd0, exp_a[10:4]});
        checkOutput("a_cnt", {28'd0, a_cnt}, {28'd0, exp_a[3:0]});
        seen7[a_if.pat_o] = seen7[a_if.pat_o] + 1;
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (!rst && b_if.pat_valid_o && b_if.pat_ready_i && !b_abort) begin
      if (sb_b.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL b_unexpected_handshake: got pat 0x%0h expected none", b_if.pat_o);
      end else begin
        exp_b = sb_b.pop_front();
        checkOutput("b_pat", {16'd0, b_if.pat_o}, {16'd0, exp_b[18:3]});
        checkOutput("b_cnt", {29'd0, b_cnt}, {29'd0, exp_b[2:0]});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int distinct;
    a_start = 0; a_abort = 0; a_we = 0; a_seed = '0; a_if.pat_ready_i = 0;
    b_start = 0; b_abort = 0; b_we = 0; b_seed = '0; b_if.pat_ready_i = 0;
    for (int i = 0; i < 128; i++) seen7[i] = 0;
    m7 = 7'h01; mcnt7 = '0; m16 = 16'h0001; mcnt16 = '0;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkOutput("a_rst_pat", {25'd0, a_if.pat_o}, 32'h01);
    checkOutput("a_rst_valid", {31'd0, a_if.pat_valid_o}, 32'd0);
    checkOutput("a_rst_cnt", {28'd0, a_cnt}, 32'd0);
    checkOutput("a_rst_busy", {31'd0, a_busy}, 32'd0);
    checkOutput("a_rst_done", {31'd0, a_done}, 32'd0);
    checkOutput("a_rst_err", {31'd0, a_err}, 32'd0);
    checkOutput("b_rst_pat", {16'd0, b_if.pat_o}, 32'h0001);

    // First run: opening patterns 0x01, 0x00, 0x40
    applyStimulus(1'b1, 1'b0, 1'b0);
    mcnt7 = '0;
    checkOutput("a_valid_after_start", {31'd0, a_if.pat_valid_o}, 32'd1);
    checkOutput("a_busy_after_start", {31'd0, a_busy}, 32'd1);
    checkOutput("a_first_pat", {25'd0, a_if.pat_o}, 32'h01);
    runHandshakesA(1);
    checkOutput("a_second_pat", {25'd0, a_if.pat_o}, 32'h00);
    runHandshakesA(1);
    checkOutput("a_third_pat", {25'd0, a_if.pat_o}, 32'h40);
    runHandshakesA(8);
    checkOutput("a_done_run1", {31'd0, a_done}, 32'd1);
    checkOutput("a_busy_run1", {31'd0, a_busy}, 32'd0);
    checkOutput("a_valid_run1", {31'd0, a_if.pat_valid_o}, 32'd0);
    checkOutput("a_cnt_run1", {28'd0, a_cnt}, 32'd10);

    // Eleven more full runs continue the sequence (120 handshakes total)
    for (int r = 1; r < 12; r++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      mcnt7 = '0;
      runHandshakesA(10);
    end
    checkOutput("a_done_run12", {31'd0, a_done}, 32'd1);

    // Abort after 3 handshakes; abort wins over a same-cycle handshake
    applyStimulus(1'b1, 1'b0, 1'b0);
    mcnt7 = '0;
    checkOutput("a_cnt_cleared", {28'd0, a_cnt}, 32'd0);
    runHandshakesA(3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("a_abort_busy", {31'd0, a_busy}, 32'd0);
    checkOutput("a_abort_done", {31'd0, a_done}, 32'd0);
    checkOutput("a_abort_cnt", {28'd0, a_cnt}, 32'd3);
    checkOutput("a_abort_pat", {25'd0, a_if.pat_o}, {25'd0, m7});

    // Restart continues from held state; 4 more makes 127 handshakes
    applyStimulus(1'b1, 1'b0, 1'b0);
    mcnt7 = '0;
    checkOutput("a_restart_cnt", {28'd0, a_cnt}, 32'd0);
    checkOutput("a_restart_pat", {25'd0, a_if.pat_o}, {25'd0, m7});
    runHandshakesA(4);
    checkOutput("a_period_pat", {25'd0, a_if.pat_o}, 32'h01);
    checkOutput("a_period_cnt", {28'd0, a_cnt}, 32'd4);

    // Stall: ready low holds pattern and count
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("a_stall_pat", {25'd0, a_if.pat_o}, 32'h01);
      checkOutput("a_stall_cnt", {28'd0, a_cnt}, 32'd4);
    end

    distinct = 0;
    for (int i = 0; i < 128; i++) begin
      if (seen7[i] == 1) distinct++;
    end
    checkOutput("a_distinct", distinct, 32'd127);
    checkOutput("a_lockup_seen", seen7[127], 32'd0);

    runHandshakesA(6);
    checkOutput("a_done_after_stall", {31'd0, a_done}, 32'd1);
    checkOutput("a_cnt_after_stall", {28'd0, a_cnt}, 32'd10);

    // Instance B: ready toggling 1,0,1,0,... after start
    applyStimulusB(1'b1, 1'b0, 1'b0);
    mcnt16 = '0;
    checkOutput("b_busy_after_start", {31'd0, b_busy}, 32'd1);
    checkOutput("b_first_pat", {16'd0, b_if.pat_o}, 32'h0001);
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) begin
        runHandshakesB(1);
      end else begin
        applyStimulusB(1'b0, 1'b0, 1'b0);
        checkOutput("b_hold_pat", {16'd0, b_if.pat_o}, {16'd0, m16});
        checkOutput("b_hold_cnt", {29'd0, b_cnt}, {29'd0, mcnt16});
      end
      if (k == 5) checkOutput("b_done_early", {31'd0, b_done}, 32'd0);
    end
    checkOutput("b_done_at_8", {31'd0, b_done}, 32'd1);
    checkOutput("b_cnt_at_8", {29'd0, b_cnt}, 32'd4);
    checkOutput("b_busy_at_8", {31'd0, b_busy}, 32'd0);

    // Start then abort at once to park B in IDLE
    applyStimulusB(1'b1, 1'b0, 1'b0);
    mcnt16 = '0;
    applyStimulusB(1'b0, 1'b1, 1'b0);
    b_abort = 1'b0;
    checkOutput("b_idle_busy", {31'd0, b_busy}, 32'd0);
    checkOutput("b_idle_done", {31'd0, b_done}, 32'd0);
    checkOutput("b_idle_pat", {16'd0, b_if.pat_o}, {16'd0, m16});

`ifdef LBIST_TPG_RESEED_EN
    b_we = 1'b1; b_seed = 16'hACE1;
    applyStimulusB(1'b0, 1'b0, 1'b0);
    checkOutput("b_seed_pat", {16'd0, b_if.pat_o}, 32'hACE1);
    checkOutput("b_seed_err", {31'd0, b_err}, 32'd0);
    b_seed = 16'hFFFF;
    applyStimulusB(1'b0, 1'b0, 1'b0);
    b_we = 1'b0;
    checkOutput("b_bad_seed_pat", {16'd0, b_if.pat_o}, 32'h0001);
    checkOutput("b_bad_seed_err", {31'd0, b_err}, 32'd1);
    applyStimulusB(1'b0, 1'b0, 1'b0);
    checkOutput("b_err_pulse_end", {31'd0, b_err}, 32'd0);

    // Seed and start together: first pattern is the new seed
    b_we = 1'b1; b_seed = 16'hACE1;
    applyStimulusB(1'b1, 1'b0, 1'b0);
    b_we = 1'b0;
    m16 = 16'hACE1; mcnt16 = '0;
    checkOutput("b_seed_start_busy", {31'd0, b_busy}, 32'd1);
    checkOutput("b_seed_start_pat", {16'd0, b_if.pat_o}, 32'hACE1);
    runHandshakesB(4);
    checkOutput("b_seed_run_done", {31'd0, b_done}, 32'd1);

    // Seed write in DONE loads and returns to IDLE
    b_we = 1'b1; b_seed = 16'h00FF;
    applyStimulusB(1'b0, 1'b0, 1'b0);
    b_we = 1'b0;
    checkOutput("b_done_seed_pat", {16'd0, b_if.pat_o}, 32'h00FF);
    checkOutput("b_done_seed_idle", {31'd0, b_done}, 32'd0);
`else
    b_we = 1'b1; b_seed = 16'h1234;
    applyStimulusB(1'b0, 1'b0, 1'b0);
    b_we = 1'b0;
    checkOutput("b_noseed_pat", {16'd0, b_if.pat_o}, {16'd0, m16});
    checkOutput("b_noseed_err", {31'd0, b_err}, 32'd0);
    applyStimulusB(1'b0, 1'b0, 1'b0);
    checkOutput("b_noseed_err2", {31'd0, b_err}, 32'd0);

    // DONE is left only through start
    applyStimulusB(1'b1, 1'b0, 1'b0);
    mcnt16 = '0;
    runHandshakesB(4);
    b_we = 1'b1; b_seed = 16'h1234;
    applyStimulusB(1'b0, 1'b0, 1'b0);
    b_we = 1'b0;
    checkOutput("b_noseed_done_stays", {31'd0, b_done}, 32'd1);
    checkOutput("b_noseed_done_pat", {16'd0, b_if.pat_o}, {16'd0, m16});
`endif

    // Reset mid-run on A; start in the reset cycle is ignored
    applyStimulus(1'b1, 1'b0, 1'b0);
    mcnt7 = '0;
    runHandshakesA(2);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    a_start = 1'b0;
    m7 = 7'h01;
    checkOutput("a_midrst_pat", {25'd0, a_if.pat_o}, 32'h01);
    checkOutput("a_midrst_valid", {31'd0, a_if.pat_valid_o}, 32'd0);
    checkOutput("a_midrst_cnt", {28'd0, a_cnt}, 32'd0);
    checkOutput("a_midrst_busy", {31'd0, a_busy}, 32'd0);
    checkOutput("a_midrst_done", {31'd0, a_done}, 32'd0);
    checkOutput("a_midrst_err", {31'd0, a_err}, 32'd0);
    tick();
    checkOutput("a_midrst_still_idle", {31'd0, a_busy}, 32'd0);

    checkOutput("a_queue_empty", sb_a.size(), 32'd0);
    checkOutput("b_queue_empty", sb_b.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
